// File: rtl/alu_exec_unit.sv
// Single-cycle ALU execute stage: ALU control decode, ALU, PC+4 and branch target,
// all registered so every output is exactly one cycle behind its inputs.
module alu_exec_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [2:0]  aluop,
    input  logic [3:0]  funct,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] pc,
    input  logic [31:0] imm_ext,
    output logic        out_valid,
    output logic [31:0] result,
    output logic        zero,
    output logic        negative,
    output logic [3:0]  gout,
    output logic [31:0] pc_plus4,
    output logic [31:0] branch_target
);

    logic [3:0]  w_gout;
    logic [31:0] w_result;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_target;

    always_comb begin
        w_gout = 4'b0010;
        case (aluop)
            3'b000: w_gout = 4'b0010;
            3'b001: w_gout = 4'b0110;
            3'b011: w_gout = 4'b0000;
            3'b100: w_gout = 4'b0001;
            3'b101: w_gout = 4'b0111;
            3'b110: w_gout = 4'b1000;
            3'b111: w_gout = 4'b0010;
            3'b010: begin
                // R-type: unlisted funct codes (including jr) fall back to add
                case (funct)
                    4'b0000: w_gout = 4'b0010;
                    4'b0010: w_gout = 4'b0110;
                    4'b0100: w_gout = 4'b0000;
                    4'b0101: w_gout = 4'b0001;
                    4'b0110: w_gout = 4'b0011;
                    4'b0111: w_gout = 4'b1100;
                    4'b1010: w_gout = 4'b0111;
                    default: w_gout = 4'b0010;
                endcase
            end
            default: w_gout = 4'b0010;
        endcase
    end

    always_comb begin
        w_result = 32'd0;
        case (w_gout)
            4'b0000: w_result = a & b;
            4'b0001: w_result = a | b;
            4'b0010: w_result = a + b;
            4'b0011: w_result = a ^ b;
            4'b0110: w_result = a - b;
            4'b0111: w_result = {31'd0, ($signed(a) < $signed(b))};
            4'b1000: w_result = a;
            4'b1100: w_result = ~(a | b);
            default: w_result = 32'd0;
        endcase
    end

    assign w_pc_plus4      = pc + 32'd4;
    assign w_branch_target = w_pc_plus4 + {imm_ext[29:0], 2'b00};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid     <= 1'b0;
            result        <= 32'd0;
            zero          <= 1'b0;
            negative      <= 1'b0;
            gout          <= 4'd0;
            pc_plus4      <= 32'd0;
            branch_target <= 32'd0;
        end else begin
            out_valid     <= in_valid;
            result        <= w_result;
            zero          <= (w_result == 32'd0);
            negative      <= w_result[31];
            gout          <= w_gout;
            pc_plus4      <= w_pc_plus4;
            branch_target <= w_branch_target;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: an operation-level model predicts every output
// one cycle after each edge, plus literal expectations for the key vectors.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [2:0]  aluop = 3'd0;
    logic [3:0]  funct = 4'd0;
    logic [31:0] a = 32'd0, b = 32'd0, pc = 32'd0, imm_ext = 32'd0;
    logic        out_valid, zero, negative;
    logic [31:0] result, pc_plus4, branch_target;
    logic [3:0]  gout;

    int pass_cnt = 0;
    int tot_cnt  = 0;
    bit chk_en   = 1'b0;

    logic        e_valid, e_zero, e_neg;
    logic [31:0] e_result, e_pc4, e_bt;
    logic [3:0]  e_gout;

    alu_exec_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .aluop(aluop), .funct(funct),
        .a(a), .b(b), .pc(pc), .imm_ext(imm_ext), .out_valid(out_valid), .result(result),
        .zero(zero), .negative(negative), .gout(gout), .pc_plus4(pc_plus4),
        .branch_target(branch_target)
    );

    always #5 clk = ~clk;

    typedef enum int {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_PASS} op_e;

    function automatic void model(input logic [2:0] op_sel, input logic [3:0] fn,
                                  input logic [31:0] x, input logic [31:0] y,
                                  output logic [3:0] g, output logic [31:0] r);
        op_e op;
        longint sx, sy;
        case (op_sel)
            3'd1: op = OP_SUB;
            3'd3: op = OP_AND;
            3'd4: op = OP_OR;
            3'd5: op = OP_SLT;
            3'd6: op = OP_PASS;
            3'd2: begin
                if      (fn == 4'd2)  op = OP_SUB;
                else if (fn == 4'd4)  op = OP_AND;
                else if (fn == 4'd5)  op = OP_OR;
                else if (fn == 4'd6)  op = OP_XOR;
                else if (fn == 4'd7)  op = OP_NOR;
                else if (fn == 4'd10) op = OP_SLT;
                else                  op = OP_ADD;
            end
            default: op = OP_ADD;
        endcase
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (op)
            OP_ADD:  begin g = 4'd2;  r = 32'((longint'(x) + longint'(y)) % 64'h1_0000_0000); end
            OP_SUB:  begin g = 4'd6;  r = 32'((longint'(x) - longint'(y) + 64'h1_0000_0000) % 64'h1_0000_0000); end
            OP_AND:  begin g = 4'd0;  r = x & y; end
            OP_OR:   begin g = 4'd1;  r = x | y; end
            OP_XOR:  begin g = 4'd3;  r = x ^ y; end
            OP_NOR:  begin g = 4'd12; r = ~(x | y); end
            OP_SLT:  begin g = 4'd7;  r = (sx < sy) ? 32'd1 : 32'd0; end
            default: begin g = 4'd8;  r = x; end
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Model: predict what the outputs must hold after this edge
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            e_valid = 0; e_zero = 0; e_neg = 0; e_result = 0; e_pc4 = 0; e_bt = 0; e_gout = 0;
        end else begin
            model(aluop, funct, a, b, e_gout, e_result);
            e_valid = in_valid;
            e_zero  = (e_result == 0);
            e_neg   = e_result[31];
            e_pc4   = 32'((longint'(pc) + 4) % 64'h1_0000_0000);
            e_bt    = 32'((longint'(e_pc4) + longint'(imm_ext) * 4) % 64'h1_0000_0000);
        end
    end

    // Compare process: every cycle, shortly after the edge
    always @(posedge clk) begin
        #1;
        if (chk_en && !reset) begin
            check("m_valid",  {31'd0, out_valid}, {31'd0, e_valid});
            check("m_result", result, e_result);
            check("m_zero",   {31'd0, zero}, {31'd0, e_zero});
            check("m_neg",    {31'd0, negative}, {31'd0, e_neg});
            check("m_gout",   {28'd0, gout}, {28'd0, e_gout});
            check("m_pc4",    pc_plus4, e_pc4);
            check("m_bt",     branch_target, e_bt);
        end
    end

    task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] fn,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] p, input logic [31:0] imm);
        @(negedge clk);
        in_valid = v; aluop = op; funct = fn; a = x; b = y; pc = p; imm_ext = imm;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_result"}, result, 32'd0);
        check({tag, "_zero"}, {31'd0, zero}, 32'd0);
        check({tag, "_neg"}, {31'd0, negative}, 32'd0);
        check({tag, "_gout"}, {28'd0, gout}, 32'd0);
        check({tag, "_pc4"}, pc_plus4, 32'd0);
        check({tag, "_bt"}, branch_target, 32'd0);
    endtask

    initial begin
        #2;
        check_all_zero("rst_init");
        @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;

        drive(1, 3'b000, 4'd0, 32'd5, 32'd7, 32'h100, 32'd0);
        settle();
        check("add_result", result, 32'd12);
        check("add_zero", {31'd0, zero}, 32'd0);
        check("add_gout", {28'd0, gout}, 32'h2);
        check("add_valid", {31'd0, out_valid}, 32'd1);

        drive(1, 3'b001, 4'd0, 32'h1234, 32'h1234, 32'h0, 32'd0);
        settle();
        check("sub_result", result, 32'd0);
        check("sub_zero", {31'd0, zero}, 32'd1);
        check("sub_gout", {28'd0, gout}, 32'h6);

        drive(1, 3'b010, 4'b1010, 32'h8000_0000, 32'd1, 32'h0, 32'd0);
        settle();
        check("slt_neg_lt", result, 32'd1);
        check("slt_gout", {28'd0, gout}, 32'h7);
        drive(0, 3'b010, 4'b1010, 32'd1, 32'h8000_0000, 32'h0, 32'd0);
        settle();
        check("slt_pos_lt", result, 32'd0);
        check("slt_invalid", {31'd0, out_valid}, 32'd0);

        drive(1, 3'b000, 4'd0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFC, 32'd0);
        settle();
        check("wrap_result", result, 32'd0);
        check("wrap_zero", {31'd0, zero}, 32'd1);
        check("wrap_pc4", pc_plus4, 32'd0);

        drive(1, 3'b110, 4'd0, 32'h8000_0001, 32'd0, 32'h8, 32'hFFFF_FFFF);
        settle();
        check("bt_pc4", pc_plus4, 32'hC);
        check("bt_neg_off", branch_target, 32'h8);
        check("pass_result", result, 32'h8000_0001);
        check("pass_neg", {31'd0, negative}, 32'd1);
        drive(1, 3'b011, 4'd0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h8, 32'd3);
        settle();
        check("bt_pos_off", branch_target, 32'h18);
        check("and_result", result, 32'h00F0_1200);

        // Sweep the full decode space with fixed operands; the model checks each cycle
        for (int op = 0; op < 8; op++)
            for (int fn = 0; fn < 16; fn++)
                drive(((op + fn) % 3) != 0, 3'(op), 4'(fn), 32'hA5A5_0F0F, 32'h5A5A_FFF0,
                      32'h1000 + 32'(fn * 4), 32'(fn - 8));
        drive(1, 3'b010, 4'b0111, 32'h0F00_0000, 32'h00F0_0000, 32'h40, 32'd1);
        settle();
        check("nor_result", result, 32'hF00F_FFFF);
        check("nor_gout", {28'd0, gout}, 32'hC);

        // Asynchronous reset between edges, then recovery on the next edge
        drive(1, 3'b100, 4'd0, 32'h0000_00F0, 32'h0000_000F, 32'h20, 32'd2);
        settle();
        check("pre_rst_or", result, 32'hFF);
        #1;
        reset = 1'b1;
        #1;
        check_all_zero("rst_async");
        @(negedge clk);
        reset = 1'b0;
        settle();
        check("rec_result", result, 32'hFF);
        check("rec_valid", {31'd0, out_valid}, 32'd1);
        check("rec_pc4", pc_plus4, 32'h24);
        check("rec_bt", branch_target, 32'h2C);

        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset: clk and reset.
REQ-002 Port `clk`: input, 1 bit; all state updates on its rising edge.
REQ-003 Port `reset`: input, 1 bit; asynchronous, active-high; clears all registers.
REQ-004 Port `in_valid`: input, 1 bit; operands and controls are valid this cycle.
REQ-005 Port `aluop`: input, 3 bits; {aluop2, aluop1, aluop0} from the main control unit.
REQ-006 Port `funct`: input, 4 bits; instruction bits [3:0].
REQ-007 Port `a`: input, 32 bits; ALU operand A (register rs).
REQ-008 Port `b`: input, 32 bits; ALU operand B (rt, or the sign-extended immediate).
REQ-009 Port `pc`: input, 32 bits; current program counter.
REQ-010 Port `imm_ext`: input, 32 bits; sign-extended 16-bit offset, not yet shifted.
REQ-011 Port `out_valid`: output, 1 bit; registered copy of `in_valid`.
REQ-012 Port `result`: output, 32 bits; registered ALU result.
REQ-013 Port `zero`: output, 1 bit; registered flag, 1 when the ALU result is 0.
REQ-014 Port `negative`: output, 1 bit; registered ALU result bit 31.
REQ-015 Port `gout`: output, 4 bits; registered ALU control code.
REQ-016 Port `pc_plus4`: output, 32 bits; registered pc+4.
REQ-017 Port `branch_target`: output, 32 bits; registered (pc+4)+(imm_ext<<2).

Function
REQ-018 The ALU control decode SHALL be combinational from `aluop`:
- 000 -> 0010 (add; lw/sw/addi).
- 001 -> 0110 (sub; beq/bne).
- 011 -> 0000 (and; andi).
- 100 -> 0001 (or; ori).
- 101 -> 0111 (slt; slti).
- 110 -> 1000 (pass A; bgez/bgtz/blez/bltz).
- 111 -> 0010 (add).
- 010 -> decode by `funct`, per REQ-019.
REQ-019 The R-type decode (aluop=010) SHALL map `funct` to `gout` as follows:
- 0000 -> 0010; 0010 -> 0110; 0100 -> 0000; 0101 -> 0001.
- 0110 -> 0011 (xor); 0111 -> 1100 (nor); 1010 -> 0111; 1000 (jr) -> 0010.
- Any other `funct` value -> 0010.
REQ-020 The ALU operations SHALL be selected by `gout`:
- 0000 a&b; 0001 a|b; 0010 a+b; 0011 a^b.
- 0110 a-b; 0111 signed(a)<signed(b) ? 1 : 0; 1000 a; 1100 ~(a|b).
- Any other code -> 0.
REQ-021 All arithmetic SHALL wrap modulo 2^32, with no overflow detection and no carry output.
REQ-022 `zero` SHALL be 1 if and only if the 32-bit ALU result equals 0, and `negative` SHALL equal result bit 31.
REQ-023 `pc_plus4` SHALL equal pc+32'h4, wrapping modulo 2^32.
REQ-024 `branch_target` SHALL equal pc_plus4 + {imm_ext[29:0],2'b00}, wrapping modulo 2^32.
REQ-025 On each rising `clk` edge not in reset, all outputs SHALL load the combinational values computed from the current inputs, giving a latency of exactly 1 cycle.
REQ-026 Outputs SHALL update every cycle regardless of `in_valid`, and `out_valid` SHALL be `in_valid` delayed by 1 cycle; there is no backpressure.
REQ-027 Outputs SHALL be stable between clock edges and SHALL NOT depend combinationally on the inputs.

Reset
REQ-028 While `reset` is high, `out_valid`, `result`, `zero`, `negative`, `gout`, `pc_plus4` and `branch_target` SHALL be 0, taking effect asynchronously without a clock edge.
REQ-029 A reset asserted mid-stream SHALL discard the pending result, and the first edge after deassertion SHALL capture the current inputs normally.

Verification
REQ-030 The bench SHALL cover add: aluop=000, a=5, b=7 -> next cycle result=12, zero=0, gout=0010.
REQ-031 The bench SHALL cover sub to zero: aluop=001, a=b=0x1234 -> result=0, zero=1, gout=0110.
REQ-032 The bench SHALL cover signed slt: aluop=010, funct=1010, a=0x80000000, b=1 -> result=1; with a=1, b=0x80000000 -> result=0.
REQ-033 The bench SHALL cover wrap: aluop=000, a=0xFFFFFFFF, b=1 -> result=0, zero=1; pc=0xFFFFFFFC -> pc_plus4=0.
REQ-034 The bench SHALL cover the branch target: pc=0x8, imm_ext=0xFFFFFFFF -> pc_plus4=0xC, branch_target=0x8; imm_ext=3 -> branch_target=0x18.
REQ-035 The bench SHALL cover async reset: drive valid inputs, assert reset between edges -> all outputs 0 immediately; deassert, one edge -> outputs reflect the current inputs and out_valid equals in_valid.
